// File: rtl/go_initiator.sv
`default_nettype none
// ============================================================================
// Module   : go_initiator
// Purpose  : Debounced start button -> held go level -> wait for worker done
//            rising edge with timeout; tracks completed runs and error status.
// Revision : 1.0  initial release
// ============================================================================
module go_initiator #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned GO_HOLD_CYCLES  = 3000004,
    parameter int unsigned TIMEOUT_CYCLES  = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn_n,
    input  logic       done_in,
    output logic       go_out,
    output logic       busy,
    output logic       done_pulse,
    output logic [7:0] run_count,
    output logic       timeout_err
);

    localparam logic [31:0] c_deb_last     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] c_go_last      = 32'(GO_HOLD_CYCLES - 1);
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_COMPLETE  = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  btn_sync_q, btn_sync_d;
    logic [2:0]  done_sync_q, done_sync_d;
    logic        deb_q, deb_d;
    logic        deb_dly_q, deb_dly_d;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic [31:0] busy_cnt_q, busy_cnt_d;
    logic [7:0]  run_count_q, run_count_d;
    logic        go_q, go_d;
    logic        busy_q, busy_d;
    logic        done_pulse_q, done_pulse_d;
    logic        timeout_err_q, timeout_err_d;

    logic        pressed;
    logic        start_pulse;
    logic        done_rise;

    assign pressed     = ~btn_sync_q[1];
    assign start_pulse = deb_q & ~deb_dly_q;
    assign done_rise   = done_sync_q[1] & ~done_sync_q[2];

    always_comb begin
        btn_sync_d  = {btn_sync_q[0], start_btn_n};
        done_sync_d = {done_sync_q[1:0], done_in};

        // Any sample agreeing with the accepted level restarts the count.
        deb_d     = deb_q;
        deb_cnt_d = 32'd0;
        if (pressed != deb_q) begin
            if (deb_cnt_q == c_deb_last) begin
                deb_d = pressed;
            end else begin
                deb_cnt_d = deb_cnt_q + 32'd1;
            end
        end
        deb_dly_d = deb_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (done_rise)                     state_d = ST_COMPLETE;
                else if (busy_cnt_q == c_go_last)  state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_rise)                          state_d = ST_COMPLETE;
                else if (busy_cnt_q == c_timeout_last)  state_d = ST_ERROR;
            end
            ST_COMPLETE: state_d = ST_IDLE;
            ST_ERROR: begin
                if (start_pulse) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_cnt_d = busy_cnt_q;
        if (state_q == ST_IDLE && state_d == ST_ARM) begin
            busy_cnt_d = 32'd0;
        end else if (state_q == ST_ARM || state_q == ST_WAIT_DONE) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
        end

        run_count_d = run_count_q;
        if (state_d == ST_COMPLETE && state_q != ST_COMPLETE) begin
            run_count_d = run_count_q + 8'd1;
        end

        // Outputs registered from the next state so they track state_q exactly.
        go_d          = (state_d == ST_ARM);
        busy_d        = (state_d == ST_ARM) || (state_d == ST_WAIT_DONE);
        done_pulse_d  = (state_d == ST_COMPLETE);
        timeout_err_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            btn_sync_q    <= 2'b11;
            done_sync_q   <= 3'b000;
            deb_q         <= 1'b0;
            deb_dly_q     <= 1'b0;
            deb_cnt_q     <= 32'd0;
            busy_cnt_q    <= 32'd0;
            run_count_q   <= 8'd0;
            go_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_pulse_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_sync_q    <= btn_sync_d;
            done_sync_q   <= done_sync_d;
            deb_q         <= deb_d;
            deb_dly_q     <= deb_dly_d;
            deb_cnt_q     <= deb_cnt_d;
            busy_cnt_q    <= busy_cnt_d;
            run_count_q   <= run_count_d;
            go_q          <= go_d;
            busy_q        <= busy_d;
            done_pulse_q  <= done_pulse_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign go_out      = go_q;
    assign busy        = busy_q;
    assign done_pulse  = done_pulse_q;
    assign run_count   = run_count_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
